write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer_pkg.sv | 26 ++
 rtl/write_buffer_if.sv | 21 ++
 rtl/write_buffer_fifo.sv | 80 ++++++++
 rtl/write_buffer.sv | 99 +++++++++
 tb/tb_write_buffer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/write_buffer_pkg.sv
// Shared bus definitions for the posted-store write buffer: bus FSM encodings,
// arbiter slot indices and the FIFO entry layout.
package write_buffer_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_WRITE = 2'd1,
    BUS_GAP   = 2'd2
  } bus_state_e;

  // Arbiter slot indices of the masters sharing the OR-combined bus
  localparam int BUS_SLOT_ICACHE = 0;
  localparam int BUS_SLOT_DCACHE = 1;
  localparam int BUS_SLOT_WBUF   = 2;
  localparam int BUS_SLOTS       = 3;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [31:0] byte_addr(input logic [29:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/write_buffer_if.sv
// Bus-side handshake of the write buffer; master is the buffer, slave is the
// arbiter/memory side.
interface write_buffer_if;
  logic        bus_req;
  logic        bus_ack;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_ready;

  modport master (
    output bus_req, bus_addr, bus_wdata, bus_rd, bus_wr,
    input  bus_ack, bus_ready
  );

  modport slave (
    input  bus_req, bus_addr, bus_wdata, bus_rd, bus_wr,
    output bus_ack, bus_ready
  );
endinterface

// File: rtl/write_buffer_fifo.sv
// Circular store FIFO with word-address CAM probe; the youngest matching
// entry forwards its data and the tail-most entry can be merged in place.
module wb_fifo
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc,
  input  logic                     merge,
  input  logic [29:0]              push_addr,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  input  logic [29:0]              probe_addr,
  output wb_entry_t                head_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     tail_match,
  output logic                     tail_is_head,
  output logic                     hit,
  output logic [31:0]              hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       entries [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   last;
  logic [PW-1:0]   probe_idx;

  assign last         = tail - PW'(1);
  assign head_entry   = entries[head];
  assign tail_is_head = (last == head);
  assign tail_match   = (count != '0) && (entries[last].addr == push_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
      case ({alloc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset: entries are only observed when covered by count
  always_ff @(posedge clk) begin
    if (alloc)
      entries[tail] <= '{addr: push_addr, data: push_data};
    else if (merge)
      entries[last].data <= push_data;
  end

  // Walk oldest to youngest so the youngest match is the one left standing
  always_comb begin
    hit       = 1'b0;
    hit_data  = '0;
    probe_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      probe_idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (entries[probe_idx].addr == probe_addr) begin
          hit      = 1'b1;
          hit_data = entries[probe_idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Posted-store write buffer: accepts DCache stores, forwards them to loads and
// drains them in order onto the shared bus through an IDLE/WRITE/GAP FSM.
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [31:0]           wr_addr,
  input  logic [31:0]           wr_data,
  output logic                  wr_full,
  input  logic [31:0]           rd_addr,
  output logic                  rd_hit,
  output logic [31:0]           rd_data,
  output logic                  drained,
  write_buffer_if.master        bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  bus_state_e     state;
  bus_state_e     state_next;
  logic [CW-1:0]  count;
  wb_entry_t      head_entry;
  logic           tail_match;
  logic           tail_is_head;
  logic           merge;
  logic           alloc;
  logic           pop;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0]};

  // A merge never targets the entry currently on the bus, and it is allowed
  // even when the buffer is full since it needs no new slot
  assign wr_full = (count == CW'(DEPTH));
  assign merge   = wr_req && tail_match && !(tail_is_head && state == BUS_WRITE);
  assign alloc   = wr_req && !merge && !wr_full;
  assign pop     = (state == BUS_WRITE) && bus.bus_ready;
  assign drained = (count == '0) && (state == BUS_IDLE);
  assign bus.bus_rd = 1'b0;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .alloc        (alloc),
    .merge        (merge),
    .push_addr    (wr_addr[31:2]),
    .push_data    (wr_data),
    .pop          (pop),
    .probe_addr   (rd_addr[31:2]),
    .head_entry   (head_entry),
    .count        (count),
    .tail_match   (tail_match),
    .tail_is_head (tail_is_head),
    .hit          (rd_hit),
    .hit_data     (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= BUS_IDLE;
    else
      state <= state_next;
  end

  // Bus outputs are zero outside WRITE because the bus is OR-combined
  always_comb begin
    state_next    = state;
    bus.bus_req   = 1'b0;
    bus.bus_wr    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    case (state)
      BUS_IDLE: begin
        bus.bus_req = (count != '0);
        if (bus.bus_ack && count != '0)
          state_next = BUS_WRITE;
      end
      BUS_WRITE: begin
        bus.bus_req   = 1'b1;
        bus.bus_wr    = 1'b1;
        bus.bus_addr  = byte_addr(head_entry.addr);
        bus.bus_wdata = head_entry.data;
        if (bus.bus_ready)
          state_next = BUS_GAP;
      end
      BUS_GAP: begin
        state_next = BUS_IDLE;
      end
      default: begin
        state_next = BUS_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer: reset, single store latency,
// full/back-pressure, coalescing, ordering, slow slave and mid-write reset.
module tb_write_buffer;

  logic        clk;
  logic        rst;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_full;
  logic [31:0] rd_addr;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        drained;

  int total;
  int bad;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  write_buffer_if bus_if();

  write_buffer #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_full (wr_full),
    .rd_addr (rd_addr),
    .rd_hit  (rd_hit),
    .rd_data (rd_data),
    .drained (drained),
    .bus     (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Steps until drained (bounded), logging every completed bus write
  task automatic drain_collect(input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      if (bus_if.bus_wr && bus_if.bus_ready) begin
        got_addr.push_back(bus_if.bus_addr);
        got_data.push_back(bus_if.bus_wdata);
      end
      if (drained) break;
      cyc();
    end
    total++;
    if (drained !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drain_timeout got=%0b exp=1", drained);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_ready = 1'b0;
    cyc();
    total++; if (drained !== 1'b1) begin bad++; $display("[TB] FAIL reset_drained got=%0b exp=1", drained); end
    total++; if (wr_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_full got=%0b exp=0", wr_full); end
    total++; if (rd_hit !== 1'b0 || rd_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_rd got=%0b/%0h exp=0/0", rd_hit, rd_data); end
    total++;
    if ({bus_if.bus_req, bus_if.bus_wr, bus_if.bus_rd} !== 3'b000 || bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_bus got=%0b%0b%0b %0h %0h exp=000 0 0", bus_if.bus_req, bus_if.bus_wr, bus_if.bus_rd, bus_if.bus_addr, bus_if.bus_wdata);
    end
    cyc();
    rst = 1'b0;
    cyc();
    total++; if (drained !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_drained got=%0b exp=1", drained); end
  endtask

  task automatic test_single();
    bus_if.bus_ack = 1'b1; bus_if.bus_ready = 1'b1;
    wr_req = 1'b1; wr_addr = 32'h100; wr_data = 32'hDEADBEEF; rd_addr = 32'h100;
    #1;
    total++; if (rd_hit !== 1'b0) begin bad++; $display("[TB] FAIL single_same_cycle_fwd got=%0b exp=0", rd_hit); end
    cyc();
    wr_req = 1'b0; rd_addr = 32'h103;
    #1;
    total++; if (rd_hit !== 1'b1 || rd_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_fwd got=%0b/%0h exp=1/deadbeef", rd_hit, rd_data); end
    total++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_wr !== 1'b0) begin bad++; $display("[TB] FAIL single_c1_bus got=%0b%0b exp=10", bus_if.bus_req, bus_if.bus_wr); end
    cyc();
    total++;
    if (bus_if.bus_wr !== 1'b1 || bus_if.bus_addr !== 32'h100 || bus_if.bus_wdata !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL single_c2_write got=%0b %0h %0h exp=1 100 deadbeef", bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_wdata);
    end
    cyc();
    total++;
    if (bus_if.bus_req !== 1'b0 || bus_if.bus_wr !== 1'b0 || bus_if.bus_addr !== 32'h0 || drained !== 1'b0 || rd_hit !== 1'b0) begin
      bad++; $display("[TB] FAIL single_gap got=req%0b wr%0b %0h drained%0b hit%0b exp=0 0 0 0 0", bus_if.bus_req, bus_if.bus_wr, bus_if.bus_addr, drained, rd_hit);
    end
    cyc();
    total++; if (drained !== 1'b1) begin bad++; $display("[TB] FAIL single_c4_drained got=%0b exp=1", drained); end
  endtask

  task automatic test_full();
    bus_if.bus_ack = 1'b0; bus_if.bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = 32'h400 + 32'(4 * i); wr_data = 32'(8'h11 * (i + 1));
      cyc();
    end
    wr_addr = 32'h410; wr_data = 32'h55; rd_addr = 32'h410;
    #1;
    total++; if (wr_full !== 1'b1) begin bad++; $display("[TB] FAIL full_after_four got=%0b exp=1", wr_full); end
    cyc();
    total++; if (wr_full !== 1'b1 || rd_hit !== 1'b0) begin bad++; $display("[TB] FAIL full_fifth_held got=full%0b hit%0b exp=1 0", wr_full, rd_hit); end
    total++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_wr !== 1'b0) begin bad++; $display("[TB] FAIL full_waiting_ack got=%0b%0b exp=10", bus_if.bus_req, bus_if.bus_wr); end
    bus_if.bus_ack = 1'b1;
    cyc();
    total++;
    if (bus_if.bus_wr !== 1'b1 || bus_if.bus_addr !== 32'h400 || bus_if.bus_wdata !== 32'h11) begin
      bad++; $display("[TB] FAIL full_first_write got=%0b %0h %0h exp=1 400 11", bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_wdata);
    end
    cyc();
    total++; if (wr_full !== 1'b0) begin bad++; $display("[TB] FAIL full_after_pop got=%0b exp=0", wr_full); end
    cyc();
    wr_req = 1'b0;
    #1;
    total++; if (wr_full !== 1'b1 || rd_hit !== 1'b1 || rd_data !== 32'h55) begin bad++; $display("[TB] FAIL full_fifth_accepted got=full%0b hit%0b %0h exp=1 1 55", wr_full, rd_hit, rd_data); end
    got_addr.delete(); got_data.delete();
    drain_collect(60);
    total++;
    if (got_addr.size() != 4) begin
      bad++; $display("[TB] FAIL full_write_count got=%0d exp=4", got_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (got_addr[i] !== 32'h404 + 32'(4 * i) || got_data[i] !== 32'(8'h11 * (i + 2))) begin
          bad++; $display("[TB] FAIL full_order_%0d got=%0h/%0h exp=%0h/%0h", i, got_addr[i], got_data[i], 32'h404 + 32'(4 * i), 32'(8'h11 * (i + 2)));
          break;
        end
      end
    end
  endtask

  task automatic test_coalesce();
    bus_if.bus_ack = 1'b0; bus_if.bus_ready = 1'b1;
    wr_req = 1'b1; wr_addr = 32'h200; wr_data = 32'h1;
    cyc();
    wr_data = 32'h2;
    cyc();
    wr_req = 1'b0; rd_addr = 32'h200;
    #1;
    total++; if (dut.u_fifo.count !== 3'd1) begin bad++; $display("[TB] FAIL coalesce_count got=%0d exp=1", dut.u_fifo.count); end
    total++; if (rd_hit !== 1'b1 || rd_data !== 32'h2) begin bad++; $display("[TB] FAIL coalesce_fwd got=%0b/%0h exp=1/2", rd_hit, rd_data); end
    bus_if.bus_ack = 1'b1;
    got_addr.delete(); got_data.delete();
    drain_collect(30);
    total++;
    if (got_addr.size() != 1 || got_addr[0] !== 32'h200 || got_data[0] !== 32'h2) begin
      bad++; $display("[TB] FAIL coalesce_bus got=%0d writes exp=1 write 200/2", got_addr.size());
    end
  endtask

  task automatic test_order();
    bus_if.bus_ack = 1'b0; bus_if.bus_ready = 1'b1;
    wr_req = 1'b1; wr_addr = 32'h300; wr_data = 32'hA;
    cyc();
    wr_addr = 32'h304; wr_data = 32'hB;
    cyc();
    wr_addr = 32'h300; wr_data = 32'hC;
    cyc();
    wr_req = 1'b0; rd_addr = 32'h300;
    #1;
    total++; if (dut.u_fifo.count !== 3'd3) begin bad++; $display("[TB] FAIL order_count got=%0d exp=3", dut.u_fifo.count); end
    total++; if (rd_hit !== 1'b1 || rd_data !== 32'hC) begin bad++; $display("[TB] FAIL order_youngest got=%0b/%0h exp=1/c", rd_hit, rd_data); end
    bus_if.bus_ack = 1'b1;
    got_addr.delete(); got_data.delete();
    drain_collect(40);
    total++;
    if (got_addr.size() != 3 || got_data[0] !== 32'hA || got_data[1] !== 32'hB || got_data[2] !== 32'hC
        || got_addr[0] !== 32'h300 || got_addr[1] !== 32'h304 || got_addr[2] !== 32'h300) begin
      bad++; $display("[TB] FAIL order_bus got=%0d writes exp=300/a 304/b 300/c", got_addr.size());
    end
  endtask

  task automatic test_slow_ready();
    bus_if.bus_ack = 1'b1; bus_if.bus_ready = 1'b0;
    wr_req = 1'b1; wr_addr = 32'h500; wr_data = 32'h1111;
    cyc();
    wr_req = 1'b0;
    cyc();
    wr_req = 1'b1; wr_data = 32'h2222; rd_addr = 32'h500;
    #1;
    total++; if (bus_if.bus_wr !== 1'b1 || bus_if.bus_addr !== 32'h500) begin bad++; $display("[TB] FAIL slow_enter_write got=%0b %0h exp=1 500", bus_if.bus_wr, bus_if.bus_addr); end
    cyc();
    wr_req = 1'b0;
    #1;
    total++; if (dut.u_fifo.count !== 3'd2 || rd_data !== 32'h2222) begin bad++; $display("[TB] FAIL slow_inflight_no_merge got=%0d/%0h exp=2/2222", dut.u_fifo.count, rd_data); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus_if.bus_wr !== 1'b1 || bus_if.bus_addr !== 32'h500 || bus_if.bus_wdata !== 32'h1111) begin
        bad++; $display("[TB] FAIL slow_stable_%0d got=%0b %0h %0h exp=1 500 1111", i, bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_wdata);
      end
      cyc();
    end
    bus_if.bus_ready = 1'b1;
    #1;
    total++; if (bus_if.bus_wr !== 1'b1 || bus_if.bus_wdata !== 32'h1111) begin bad++; $display("[TB] FAIL slow_release got=%0b %0h exp=1 1111", bus_if.bus_wr, bus_if.bus_wdata); end
    cyc();
    total++;
    if ({bus_if.bus_req, bus_if.bus_wr, bus_if.bus_rd} !== 3'b000 || bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 32'h0) begin
      bad++; $display("[TB] FAIL slow_gap_bus got=%0b%0b%0b %0h %0h exp=000 0 0", bus_if.bus_req, bus_if.bus_wr, bus_if.bus_rd, bus_if.bus_addr, bus_if.bus_wdata);
    end
    got_addr.delete(); got_data.delete();
    drain_collect(30);
    total++;
    if (got_addr.size() != 1 || got_addr[0] !== 32'h500 || got_data[0] !== 32'h2222) begin
      bad++; $display("[TB] FAIL slow_second_write got=%0d writes exp=1 write 500/2222", got_addr.size());
    end
  endtask

  task automatic test_reset_midwrite();
    bus_if.bus_ack = 1'b1; bus_if.bus_ready = 1'b0;
    wr_req = 1'b1; wr_addr = 32'h600; wr_data = 32'h77;
    cyc();
    wr_addr = 32'h604; wr_data = 32'h88;
    cyc();
    wr_req = 1'b0; rd_addr = 32'h604;
    #1;
    total++; if (bus_if.bus_wr !== 1'b1 || rd_hit !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre got=wr%0b hit%0b exp=1 1", bus_if.bus_wr, rd_hit); end
    rst = 1'b1;
    #1;
    total++;
    if (bus_if.bus_wr !== 1'b0 || bus_if.bus_addr !== 32'h0 || bus_if.bus_req !== 1'b0 || rd_hit !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_async_bus got=wr%0b %0h req%0b hit%0b exp=0 0 0 0", bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_req, rd_hit);
    end
    total++; if (dut.u_fifo.count !== 3'd0 || drained !== 1'b1) begin bad++; $display("[TB] FAIL midrst_state got=%0d/%0b exp=0/1", dut.u_fifo.count, drained); end
    cyc();
    rst = 1'b0;
    cyc();
    total++; if (drained !== 1'b1 || bus_if.bus_req !== 1'b0) begin bad++; $display("[TB] FAIL midrst_after got=%0b/%0b exp=1/0", drained, bus_if.bus_req); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_full();
    test_coalesce();
    test_order();
    test_slow_ready();
    test_reset_midwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
